// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: divides clk down to the pixel rate and produces
// column/line counters plus registered sync, blanking and frame-start strobes.
module vga_timing_gen #(
  parameter int CLK_DIV = 4,
  parameter int H_VIS   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_VIS   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       pixel_tick,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       Hsync,
  output logic       Vsync,
  output logic       video_on,
  output logic       frame_start
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOT - 1);
  localparam logic [9:0] H_VIS_L  = 10'(H_VIS);
  localparam logic [9:0] V_VIS_L  = 10'(V_VIS);
  localparam logic [9:0] HS_BEG   = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_BEG   = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_q, tick_d;
  logic [9:0]       hcount_q, hcount_d;
  logic [9:0]       vcount_q, vcount_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             video_on_q, video_on_d;
  logic             frame_start_q, frame_start_d;

  always_comb begin
    div_d         = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    // Tick is registered from the next divider value so it tracks div_q exactly.
    tick_d        = (div_d == DIV_LAST);
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    video_on_d    = video_on_q;
    frame_start_d = 1'b0;
    if (tick_q) begin
      hcount_d = (hcount_q == H_LAST) ? 10'd0 : hcount_q + 10'd1;
      if (hcount_q == H_LAST) begin
        vcount_d = (vcount_q == V_LAST) ? 10'd0 : vcount_q + 10'd1;
      end
      // Decode from next-state counters so flags line up with hcount/vcount.
      hsync_d       = !((hcount_d >= HS_BEG) && (hcount_d <= HS_END));
      vsync_d       = !((vcount_d >= VS_BEG) && (vcount_d <= VS_END));
      video_on_d    = (hcount_d < H_VIS_L) && (vcount_d < V_VIS_L);
      frame_start_d = (hcount_d == 10'd0) && (vcount_d == 10'd0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q         <= '0;
      tick_q        <= 1'b0;
      hcount_q      <= H_LAST;
      vcount_q      <= V_LAST;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      video_on_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      tick_q        <= tick_d;
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign pixel_tick  = tick_q;
  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign Hsync       = hsync_q;
  assign Vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 timing instance plus a tiny 10x6 instance
// (CLK_DIV=2) so that full-frame behaviour fits in a short run.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       tk_a, hs_a, vs_a, von_a, fs_a;
  logic [9:0] h_a, v_a;
  logic       tk_b, hs_b, vs_b, von_b, fs_b;
  logic [9:0] h_b, v_b;

  vga_timing_gen dut_a (
    .clk(clk), .rst_n(rst_n), .pixel_tick(tk_a), .hcount(h_a), .vcount(v_a),
    .Hsync(hs_a), .Vsync(vs_a), .video_on(von_a), .frame_start(fs_a)
  );

  // H: 4 vis, 2 fp, 2 sync (6..7), 2 bp = 10; V: 2 vis, 1 fp, 1 sync (3), 2 bp = 6.
  vga_timing_gen #(
    .CLK_DIV(2), .H_VIS(4), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_VIS(2), .V_FP(1), .V_SYNC(1), .V_BP(2)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .pixel_tick(tk_b), .hcount(h_b), .vcount(v_b),
    .Hsync(hs_b), .Vsync(vs_b), .video_on(von_b), .frame_start(fs_b)
  );

  typedef struct {
    int e;
    int h;
    int v;
    bit hs;
    bit vs;
    bit von;
    bit fs;
    bit tk;
  } vec_t;

  vec_t tab_a[$];
  vec_t tab_b[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   edge_n  = 0;

  function automatic vec_t mk(int e, int h, int v, bit hs, bit vs, bit von, bit fs, bit tk);
    vec_t t;
    t.e = e; t.h = h; t.v = v; t.hs = hs; t.vs = vs; t.von = von; t.fs = fs; t.tk = tk;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic reset_release();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    edge_n = 0;
    #1;
  endtask

  task automatic check_a(input vec_t t);
    string p;
    p = $sformatf("A e%0d", t.e);
    chk({p, " hcount"}, 32'(h_a), 32'(t.h));
    chk({p, " vcount"}, 32'(v_a), 32'(t.v));
    chk({p, " Hsync"}, 32'(hs_a), 32'(t.hs));
    chk({p, " Vsync"}, 32'(vs_a), 32'(t.vs));
    chk({p, " video_on"}, 32'(von_a), 32'(t.von));
    chk({p, " frame_start"}, 32'(fs_a), 32'(t.fs));
    chk({p, " pixel_tick"}, 32'(tk_a), 32'(t.tk));
    $display("A edge %0d: h=%0d v=%0d hs=%0b vs=%0b von=%0b fs=%0b tk=%0b",
             t.e, h_a, v_a, hs_a, vs_a, von_a, fs_a, tk_a);
  endtask

  task automatic check_b(input vec_t t);
    string p;
    p = $sformatf("B e%0d", t.e);
    chk({p, " hcount"}, 32'(h_b), 32'(t.h));
    chk({p, " vcount"}, 32'(v_b), 32'(t.v));
    chk({p, " Hsync"}, 32'(hs_b), 32'(t.hs));
    chk({p, " Vsync"}, 32'(vs_b), 32'(t.vs));
    chk({p, " video_on"}, 32'(von_b), 32'(t.von));
    chk({p, " frame_start"}, 32'(fs_b), 32'(t.fs));
    chk({p, " pixel_tick"}, 32'(tk_b), 32'(t.tk));
    $display("B edge %0d: h=%0d v=%0d hs=%0b vs=%0b von=%0b fs=%0b tk=%0b",
             t.e, h_b, v_b, hs_b, vs_b, von_b, fs_b, tk_b);
  endtask

  initial begin
    int   ticks, wraps, fs_cnt, vs_low, hs_low_ticks, von_low, viol, hs_first_h;
    logic [9:0] prev_h;
    logic       prev_hs;

    // Default instance: pixel k lands at edge 4*(k+1) after release.
    tab_a.push_back(mk(0,    799, 524, 1, 1, 0, 0, 0));
    tab_a.push_back(mk(1,    799, 524, 1, 1, 0, 0, 0));
    tab_a.push_back(mk(3,    799, 524, 1, 1, 0, 0, 1));
    tab_a.push_back(mk(4,    0,   0,   1, 1, 1, 1, 0));
    tab_a.push_back(mk(5,    0,   0,   1, 1, 1, 0, 0));
    tab_a.push_back(mk(7,    0,   0,   1, 1, 1, 0, 1));
    tab_a.push_back(mk(8,    1,   0,   1, 1, 1, 0, 0));
    tab_a.push_back(mk(2560, 639, 0,   1, 1, 1, 0, 0));
    tab_a.push_back(mk(2564, 640, 0,   1, 1, 0, 0, 0));
    tab_a.push_back(mk(2624, 655, 0,   1, 1, 0, 0, 0));
    tab_a.push_back(mk(2628, 656, 0,   0, 1, 0, 0, 0));
    tab_a.push_back(mk(3008, 751, 0,   0, 1, 0, 0, 0));
    tab_a.push_back(mk(3012, 752, 0,   1, 1, 0, 0, 0));
    tab_a.push_back(mk(3200, 799, 0,   1, 1, 0, 0, 0));
    tab_a.push_back(mk(3204, 0,   1,   1, 1, 1, 0, 0));

    // Small instance: pixel k lands at edge 2*(k+1) after release.
    tab_b.push_back(mk(0,   9, 5, 1, 1, 0, 0, 0));
    tab_b.push_back(mk(1,   9, 5, 1, 1, 0, 0, 1));
    tab_b.push_back(mk(2,   0, 0, 1, 1, 1, 1, 0));
    tab_b.push_back(mk(3,   0, 0, 1, 1, 1, 0, 1));
    tab_b.push_back(mk(4,   1, 0, 1, 1, 1, 0, 0));
    tab_b.push_back(mk(8,   3, 0, 1, 1, 1, 0, 0));
    tab_b.push_back(mk(10,  4, 0, 1, 1, 0, 0, 0));
    tab_b.push_back(mk(14,  6, 0, 0, 1, 0, 0, 0));
    tab_b.push_back(mk(16,  7, 0, 0, 1, 0, 0, 0));
    tab_b.push_back(mk(18,  8, 0, 1, 1, 0, 0, 0));
    tab_b.push_back(mk(20,  9, 0, 1, 1, 0, 0, 0));
    tab_b.push_back(mk(22,  0, 1, 1, 1, 1, 0, 0));
    tab_b.push_back(mk(42,  0, 2, 1, 1, 0, 0, 0));
    tab_b.push_back(mk(62,  0, 3, 1, 0, 0, 0, 0));
    tab_b.push_back(mk(80,  9, 3, 1, 0, 0, 0, 0));
    tab_b.push_back(mk(82,  0, 4, 1, 1, 0, 0, 0));
    tab_b.push_back(mk(120, 9, 5, 1, 1, 0, 0, 0));
    tab_b.push_back(mk(121, 9, 5, 1, 1, 0, 0, 1));
    tab_b.push_back(mk(122, 0, 0, 1, 1, 1, 1, 0));
    tab_b.push_back(mk(123, 0, 0, 1, 1, 1, 0, 1));

    reset_release();
    foreach (tab_b[i]) begin
      while (edge_n < tab_b[i].e) step();
      check_b(tab_b[i]);
    end

    // One full small frame, edges 124..243 (pixels 61..120).
    ticks = 0; wraps = 0; fs_cnt = 0; vs_low = 0; hs_low_ticks = 0; viol = 0;
    prev_h = h_b;
    for (int i = 0; i < 120; i++) begin
      step();
      if (tk_b) ticks++;
      if (fs_b) fs_cnt++;
      if (!vs_b) vs_low++;
      if (tk_b && !hs_b) hs_low_ticks++;
      if (h_b == 10'd0 && prev_h == 10'd9) wraps++;
      if (!vs_b && v_b != 10'd3) viol++;
      if (von_b != (h_b < 10'd4 && v_b < 10'd2)) viol++;
      if (hs_b != !(h_b == 10'd6 || h_b == 10'd7)) viol++;
      prev_h = h_b;
    end
    $display("B frame: ticks=%0d wraps=%0d fs=%0d vs_low=%0d hs_low_ticks=%0d viol=%0d",
             ticks, wraps, fs_cnt, vs_low, hs_low_ticks, viol);
    chk("B frame pixel_tick count", 32'(ticks), 32'd60);
    chk("B frame hcount wraps", 32'(wraps), 32'd6);
    chk("B frame frame_start count", 32'(fs_cnt), 32'd1);
    chk("B frame Vsync low clks", 32'(vs_low), 32'd20);
    chk("B frame Hsync low ticks", 32'(hs_low_ticks), 32'd12);
    chk("B frame placement violations", 32'(viol), 32'd0);
    chk("B frame end hcount", 32'(h_b), 32'd0);
    chk("B frame end vcount", 32'(v_b), 32'd0);

    reset_release();
    foreach (tab_a[i]) begin
      while (edge_n < tab_a[i].e) step();
      check_a(tab_a[i]);
    end

    // One full default line (vcount=1), edges 3205..6404.
    ticks = 0; wraps = 0; fs_cnt = 0; hs_low_ticks = 0; von_low = 0; viol = 0;
    hs_first_h = -1;
    prev_h = h_a;
    prev_hs = hs_a;
    for (int i = 0; i < 3200; i++) begin
      step();
      if (tk_a) ticks++;
      if (fs_a) fs_cnt++;
      if (!von_a) von_low++;
      if (tk_a && !hs_a) hs_low_ticks++;
      if (prev_hs && !hs_a && hs_first_h < 0) hs_first_h = int'(h_a);
      if (h_a == 10'd0 && prev_h == 10'd799) wraps++;
      if (von_a != (h_a < 10'd640 && v_a < 10'd480)) viol++;
      if (hs_a != !(h_a >= 10'd656 && h_a <= 10'd751)) viol++;
      prev_h = h_a;
      prev_hs = hs_a;
    end
    $display("A line: ticks=%0d wraps=%0d fs=%0d von_low=%0d hs_low_ticks=%0d hs_first=%0d viol=%0d",
             ticks, wraps, fs_cnt, von_low, hs_low_ticks, hs_first_h, viol);
    chk("A line pixel_tick count", 32'(ticks), 32'd800);
    chk("A line hcount wraps", 32'(wraps), 32'd1);
    chk("A line frame_start count", 32'(fs_cnt), 32'd0);
    chk("A line video_on low clks", 32'(von_low), 32'd640);
    chk("A line Hsync low ticks", 32'(hs_low_ticks), 32'd96);
    chk("A line Hsync first low hcount", 32'(hs_first_h), 32'd656);
    chk("A line placement violations", 32'(viol), 32'd0);

    // Asynchronous reset between clock edges at (300,2).
    while (edge_n < 7605) step();
    chk("A pre-reset hcount", 32'(h_a), 32'd300);
    chk("A pre-reset vcount", 32'(v_a), 32'd2);
    #3;
    rst_n = 1'b0;
    #1;
    $display("async reset: A h=%0d v=%0d hs=%0b vs=%0b von=%0b fs=%0b tk=%0b; B h=%0d v=%0d",
             h_a, v_a, hs_a, vs_a, von_a, fs_a, tk_a, h_b, v_b);
    chk("async rst A hcount", 32'(h_a), 32'd799);
    chk("async rst A vcount", 32'(v_a), 32'd524);
    chk("async rst A Hsync", 32'(hs_a), 32'd1);
    chk("async rst A Vsync", 32'(vs_a), 32'd1);
    chk("async rst A video_on", 32'(von_a), 32'd0);
    chk("async rst A frame_start", 32'(fs_a), 32'd0);
    chk("async rst A pixel_tick", 32'(tk_a), 32'd0);
    chk("async rst B hcount", 32'(h_b), 32'd9);
    chk("async rst B vcount", 32'(v_b), 32'd5);
    chk("async rst B pixel_tick", 32'(tk_b), 32'd0);

    // Restart after mid-frame reset must match power-up.
    reset_release();
    for (int i = 0; i < 5; i++) begin
      while (edge_n < tab_a[i].e) step();
      check_a(tab_a[i]);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
